// File: rtl/mux8_pkg.sv
// Shared constants and types for the registered 8:1 data selector.
package mux8_pkg;

  localparam int unsigned NUM_IN        = 8;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : mux8_pkg

// File: rtl/mux8_onehot_dec.sv
// 3-bit select code to 8-bit one-hot enable vector for the AND-OR select path.
module mux8_onehot_dec
  import mux8_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  output logic [NUM_IN-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[sel] = 1'b1;
  end

endmodule : mux8_onehot_dec

// File: rtl/mux8.sv
// Registered 8:1 selector with valid flag; defining MUX8_PARITY_EN adds the
// registered even-parity output out_par.
module mux8
  import mux8_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef MUX8_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic [NUM_IN-1:0] sel_onehot;
  logic [WIDTH-1:0]  in_arr [NUM_IN];
  logic [WIDTH-1:0]  sel_data;

  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;
  assign in_arr[6] = in6;
  assign in_arr[7] = in7;

  mux8_onehot_dec u_dec (
    .sel    (sel),
    .onehot (sel_onehot)
  );

  // Exactly one enable is hot, so OR-ing the gated inputs yields in[sel].
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_data = sel_data | (in_arr[i] & {WIDTH{sel_onehot[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= sel_data;
      end
    end
  end

`ifdef MUX8_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (in_valid) begin
      out_par <= ^sel_data;
    end
  end
`endif

endmodule : mux8

// File: tb/tb_mux8.sv
// Self-checking bench for mux8: scoreboard of expected outputs, vector table,
// and hand-written reset sequences.
module tb_mux8;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   sel;
  logic         in_valid;
  logic [W-1:0] in_d [8];
  logic [W-1:0] out;
  logic         out_valid;
`ifdef MUX8_PARITY_EN
  logic         out_par;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] out;
    logic         vld;
    logic         par;
  } exp_t;

  typedef struct {
    logic [2:0]   sel;
    logic         vld;
    logic [W-1:0] word;
  } vec_t;

  exp_t         exp_q [$];
  vec_t         vecs [12];
  logic [W-1:0] model_out;
  logic         model_par;

  always #5 clk = ~clk;

  mux8 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sel       (sel),
    .in_valid  (in_valid),
    .in0       (in_d[0]),
    .in1       (in_d[1]),
    .in2       (in_d[2]),
    .in3       (in_d[3]),
    .in4       (in_d[4]),
    .in5       (in_d[5]),
    .in6       (in_d[6]),
    .in7       (in_d[7]),
    .out       (out),
    .out_valid (out_valid)
`ifdef MUX8_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".out"}, out, e.out);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, e.vld});
`ifdef MUX8_PARITY_EN
    check({tag, ".out_par"}, {15'd0, out_par}, {15'd0, e.par});
`endif
  endtask

  // Called away from a rising edge; inputs are sampled at the next edge.
  task automatic drive(input string tag, input logic [2:0] s, input logic v);
    exp_t e;
    sel      = s;
    in_valid = v;
    if (v) begin
      model_out = in_d[s];
      model_par = ^in_d[s];
    end
    e.out = model_out;
    e.vld = v;
    e.par = model_par;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_pop(tag);
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_out = '0;
    model_par = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{3'd0, 1'b1, 16'hFFFF};
    vecs[1]  = '{3'd7, 1'b1, 16'h8001};
    vecs[2]  = '{3'd5, 1'b1, 16'h0005};
    vecs[3]  = '{3'd2, 1'b0, 16'h1234};
    vecs[4]  = '{3'd6, 1'b0, 16'hBEEF};
    vecs[5]  = '{3'd3, 1'b1, 16'h0001};
    vecs[6]  = '{3'd1, 1'b1, 16'hAAAA};
    vecs[7]  = '{3'd4, 1'b1, 16'h5555};
    vecs[8]  = '{3'd4, 1'b1, 16'h8000};
    vecs[9]  = '{3'd0, 1'b0, 16'h0000};
    vecs[10] = '{3'd6, 1'b1, 16'h7FFF};
    vecs[11] = '{3'd7, 1'b1, 16'h0000};

    rst_n    = 1'b0;
    sel      = 3'd0;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) in_d[k] = 16'hFFFF;
    reset_model();
    #12;
    check("reset.out", out, 16'h0000);
    check("reset.out_valid", {15'd0, out_valid}, 16'd0);
`ifdef MUX8_PARITY_EN
    check("reset.out_par", {15'd0, out_par}, 16'd0);
`endif
    rst_n = 1'b1;

    // Stepped select over identity data, back-to-back valid.
    for (int k = 0; k < 8; k++) in_d[k] = W'(k);
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 10; c++) drive("step", 3'(s), 1'b1);
    end

    // Vector table: non-selected inputs randomised to catch wrong routing.
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 8; k++) in_d[k] = W'($urandom);
      in_d[vecs[i].sel] = vecs[i].word;
      drive($sformatf("vec%0d", i), vecs[i].sel, vecs[i].vld);
    end

    // Asynchronous reset between edges while out holds 0007.
    for (int k = 0; k < 8; k++) in_d[k] = 16'h1111;
    in_d[7] = 16'h0007;
    drive("pre_rst", 3'd7, 1'b1);
    check("pre_rst.direct", out, 16'h0007);
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    check("async_rst.out", out, 16'h0000);
    check("async_rst.out_valid", {15'd0, out_valid}, 16'd0);
`ifdef MUX8_PARITY_EN
    check("async_rst.out_par", {15'd0, out_par}, 16'd0);
`endif
    sel      = 3'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_held.out", out, 16'h0000);
    check("rst_held.out_valid", {15'd0, out_valid}, 16'd0);
    #2;
    rst_n = 1'b1;
    drive("post_rst_idle", 3'd7, 1'b0);
    drive("post_rst_cap", 3'd7, 1'b1);
    check("post_rst.direct", out, 16'h0007);

    // Reset pulse in the middle of a back-to-back stream.
    in_d[2] = 16'hC3C3;
    drive("stream_a", 3'd2, 1'b1);
    in_d[2] = 16'h3C3C;
    sel      = 3'd2;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    reset_model();
    check("mid_stream_rst.out", out, 16'h0000);
    drive("stream_b", 3'd2, 1'b1);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mux8

// File: doc/mux8.md
MUX8 -- requirements
Module: mux8

Interface
REQ-001 Parameter WIDTH, default 16, data width of every input and of the output.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sel  input  3  selects data input 0..7.
REQ-006 in_valid  input  1  qualifies sel/data for capture this cycle.
REQ-007 in0 .. in7  input  WIDTH each  eight data inputs, index equals sel code.
REQ-008 out  output  WIDTH  registered selected data.
REQ-009 out_valid  output  1  high for the cycle out holds a newly captured value.
REQ-010 out_par  output  1  even parity of out; present only with MUX8_PARITY_EN.

Function
REQ-011 On a rising clk edge with in_valid=1, out SHALL load in[sel] (sel=0 -> in0 ... sel=7 -> in7), with 1-cycle latency.
REQ-012 On a rising clk edge with in_valid=0, out SHALL hold its previous value.
REQ-013 out_valid SHALL be a registered copy of in_valid (1-cycle latency, aligned with out).
REQ-014 All 8 sel codes are legal; no out-of-range case exists; X/Z on sel is not handled.
REQ-015 sel and data changing on the same edge as capture: the values sampled at that edge SHALL be used.
REQ-016 Back-to-back in_valid SHALL produce a new out every cycle, no bubbles.
REQ-017 Selection SHALL be lossless bitwise: no width change, no sign extension, all WIDTH bits passed.

Reset
REQ-018 rst_n=0 SHALL asynchronously force out=0, out_valid=0 (and out_par=0 when present), independent of clk.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight capture; the first capture after deassertion occurs on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-020 Macro MUX8_PARITY_EN defined: port out_par SHALL exist, registered together with out, equal to XOR-reduction of the captured word.
REQ-021 MUX8_PARITY_EN undefined: out_par port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-022 Package mux8_pkg SHALL hold NUM_IN=8, SEL_W=3, DEFAULT_WIDTH=16 and a data typedef sized by DEFAULT_WIDTH.
REQ-023 Sub-module mux8_onehot_dec (3-bit sel to 8-bit one-hot) SHALL drive an AND-OR select path; the output register stays in mux8.

Verification
REQ-024 in_k=k (k=0..7), in_valid=1, sel stepped 0..7, each held 10 cycles -> out=sel one cycle after each step, out_valid=1 throughout.
REQ-025 in0=16'hFFFF, in7=16'h8001, sel=0 then 7 -> out=16'hFFFF then 16'h8001; out_par=0 then 0 (with macro).
REQ-026 out=16'h0005 captured, in_valid=0, sel/data changed -> out stays 16'h0005, out_valid=0.
REQ-027 rst_n pulsed low between clk edges while out=16'h0007 -> out=0, out_valid=0 immediately; recovers on next valid edge.
REQ-028 in3=16'h0001, sel=3 with macro -> out_par=1; build without macro -> elaborates with no out_par port.
